nibble_serial_adder: RTL and testbench

//  Multi-cycle WIDTH-bit adder that reuses one 4-bit adder slice, one nibble per cycle, LSB nibble first.

---
 rtl/nibble_adder_pkg.sv | 23 ++
 rtl/nibble_add4.sv | 18 +
 rtl/nibble_serial_adder.sv | 116 +++++++++++
 tb/tb_nibble_serial_adder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/nibble_adder_pkg.sv
// Shared definitions for the nibble-serial adder.
//   NIB_W   : width of the reused adder slice
//   state_t : controller states
//   clog2 / idx_w : nibble index counter width helpers
package nibble_adder_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // The index counter is always at least one bit, even when only one nibble exists.
  function automatic int idx_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nibble_add4.sv
// Combinational 4-bit adder slice.
//   a4, b4 : nibble operands
//   ci     : carry in
//   s4     : nibble sum
//   co     : carry out
import nibble_adder_pkg::*;

module nibble_add4 (
  input  logic [NIB_W-1:0] a4,
  input  logic [NIB_W-1:0] b4,
  input  logic             ci,
  output logic [NIB_W-1:0] s4,
  output logic             co
);

  assign {co, s4} = (NIB_W+1)'(a4) + (NIB_W+1)'(b4) + (NIB_W+1)'(ci);

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that reuses a single 4-bit slice, one nibble per clock,
// LSB nibble first. The carry is held in a register between nibbles.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : operand handshake (in_ready high only in IDLE)
//   a, b, cin           : operands, captured at accept
//   out_valid/out_ready : result handshake (out_valid high only in DONE)
//   sum, cout           : registered result, held until the next operation
//   ovf                 : signed overflow, present only with ADDER_OVF_EN defined
// Build option: ADDER_OVF_EN adds the ovf output and its register.
import nibble_adder_pkg::*;

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIBBLES = WIDTH / NIB_W;
  localparam int IDX_W   = idx_w(NIBBLES);

  state_t             r_state, w_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [WIDTH-1:0]   r_a, r_b, r_sum;
  logic               r_carry, r_cout;
  logic [NIB_W-1:0]   w_a4, w_b4, w_s4;
  logic               w_co, w_last;

  assign w_last    = (r_idx == IDX_W'(NIBBLES-1));
  assign w_a4      = r_a[r_idx*NIB_W +: NIB_W];
  assign w_b4      = r_b[r_idx*NIB_W +: NIB_W];
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;

  nibble_add4 u_slice (
    .a4 (w_a4),
    .b4 (w_b4),
    .ci (r_carry),
    .s4 (w_s4),
    .co (w_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_nxt = RUN;
      RUN:     if (w_last)    w_nxt = DONE;
      DONE:    if (out_ready) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_a     <= a;
          r_b     <= b;
          r_carry <= cin;
          r_idx   <= '0;
        end
        RUN: begin
          r_sum[r_idx*NIB_W +: NIB_W] <= w_s4;
          r_carry <= w_co;
          // Wrap so the counter is already zero for the next operation.
          r_idx   <= w_last ? '0 : r_idx + 1'b1;
          if (w_last) r_cout <= w_co;
        end
        default: ;
      endcase
    end
  end

`ifdef ADDER_OVF_EN
  logic r_ovf;
  assign ovf = r_ovf;

  // On the last nibble the slice's MSB is the final sum MSB, so overflow
  // can be resolved in the same edge that registers cout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ovf <= 1'b0;
    else if (r_state == RUN && w_last)
      r_ovf <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_s4[NIB_W-1] != r_a[WIDTH-1]);
  end
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 16-bit instance
  logic        iv16 = 0, ir16, c16 = 0, ov16, or16 = 0, co16;
  logic [15:0] a16 = 0, b16 = 0, s16;
  // 4-bit instance
  logic        iv4 = 0, ir4, c4 = 0, ov4, or4 = 0, co4;
  logic [3:0]  a4 = 0, b4 = 0, s4;
`ifdef ADDER_OVF_EN
  logic ovf16, ovf4;
`endif

  int n_chk = 0;
  int n_fail = 0;

  nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16), .cin(c16), .out_valid(ov16), .out_ready(or16),
    .sum(s16), .cout(co16)
`ifdef ADDER_OVF_EN
    , .ovf(ovf16)
`endif
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
    .a(a4), .b(b4), .cin(c4), .out_valid(ov4), .out_ready(or4),
    .sum(s4), .cout(co4)
`ifdef ADDER_OVF_EN
    , .ovf(ovf4)
`endif
  );

  // Drive one operation into dut16 and wait (bounded) for out_valid.
  // lat counts rising edges after the accept edge; rdy_ok clears if in_ready
  // was ever seen high while the operation was in flight.
  task automatic send16(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                        output int lat, output bit rdy_ok);
    @(negedge clk);
    a16 = ta; b16 = tb; c16 = tc; iv16 = 1;
    @(posedge clk);
    @(negedge clk);
    iv16 = 0;
    lat = 0;
    rdy_ok = 1;
    while (!ov16 && lat < 50) begin
      if (ir16) rdy_ok = 0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (ir16) rdy_ok = 0;
  endtask

  task automatic handshake16();
    or16 = 1;
    @(posedge clk);
    @(negedge clk);
    or16 = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++; if (ir16 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready16 got %b want 1", ir16); end
    n_chk++; if (ov16 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid16 got %b want 0", ov16); end
    n_chk++; if ({co16, s16} !== 17'h0) begin n_fail++; $display("FAIL reset_result16 got %h want 0", {co16, s16}); end
    n_chk++; if ({ir4, ov4, co4, s4} !== 7'b1000000) begin n_fail++; $display("FAIL reset_dut4 got %b want 1000000", {ir4, ov4, co4, s4}); end
    rst_n = 1;
  endtask

  task automatic test_basic();
    int lat; bit rok;
    send16(16'hFFFF, 16'h0001, 1'b0, lat, rok);
    n_chk++; if (lat !== 4) begin n_fail++; $display("FAIL latency got %0d want 4", lat); end
    n_chk++; if ({co16, s16} !== 17'h10000) begin n_fail++; $display("FAIL ffff_plus_1 got %h want 10000", {co16, s16}); end
    handshake16();
    n_chk++; if ({ov16, ir16} !== 2'b01) begin n_fail++; $display("FAIL after_handshake ov/ir got %b want 01", {ov16, ir16}); end
    send16(16'h1234, 16'h4321, 1'b1, lat, rok);
    n_chk++; if (rok !== 1'b1) begin n_fail++; $display("FAIL in_ready_busy got high during op want low"); end
    n_chk++; if ({co16, s16} !== 17'h05556) begin n_fail++; $display("FAIL 1234_4321_c got %h want 05556", {co16, s16}); end
    n_chk++; if (ir16 !== 1'b0) begin n_fail++; $display("FAIL in_ready_done got %b want 0", ir16); end
    handshake16();
    n_chk++; if (ir16 !== 1'b1) begin n_fail++; $display("FAIL in_ready_idle got %b want 1", ir16); end
  endtask

  task automatic test_backpressure();
    int lat; bit rok;
    logic [15:0] ta, tb;
    logic tc;
    logic [16:0] exp;
    ta = 16'($urandom); tb = 16'($urandom); tc = 1'($urandom);
    exp = {1'b0, ta} + {1'b0, tb} + 17'(tc);
    send16(ta, tb, tc, lat, rok);
    for (int i = 0; i < 5; i++) begin
      iv16 = 1; a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      n_chk++; if ({ov16, ir16, co16, s16} !== {2'b10, exp}) begin
        n_fail++; $display("FAIL backpressure_%0d got ov=%b ir=%b res=%h want ov=1 ir=0 res=%h", i, ov16, ir16, {co16, s16}, exp);
      end
    end
    iv16 = 0;
    handshake16();
    n_chk++; if ({ir16, co16, s16} !== {1'b1, exp}) begin
      n_fail++; $display("FAIL idle_hold got ir=%b res=%h want ir=1 res=%h", ir16, {co16, s16}, exp);
    end
  endtask

  task automatic test_reset_mid();
    int lat; bit rok;
    @(negedge clk);
    a16 = 16'hABCD; b16 = 16'h1111; c16 = 0; iv16 = 1;
    @(posedge clk);
    @(negedge clk);
    iv16 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    n_chk++; if ({ov16, ir16, co16, s16} !== {2'b01, 17'h0}) begin
      n_fail++; $display("FAIL mid_reset got ov=%b ir=%b res=%h want ov=0 ir=1 res=0", ov16, ir16, {co16, s16});
    end
    @(negedge clk);
    rst_n = 1;
    send16(16'h00FF, 16'h0001, 1'b0, lat, rok);
    n_chk++; if ({co16, s16} !== 17'h00100 || lat !== 4) begin
      n_fail++; $display("FAIL post_reset got %h lat %0d want 00100 lat 4", {co16, s16}, lat);
    end
    handshake16();
  endtask

`ifdef ADDER_OVF_EN
  task automatic test_ovf();
    int lat; bit rok;
    send16(16'h7FFF, 16'h0001, 1'b0, lat, rok);
    n_chk++; if ({ovf16, co16, s16} !== {1'b1, 17'h08000}) begin n_fail++; $display("FAIL ovf_7fff got ovf=%b res=%h want 1 08000", ovf16, {co16, s16}); end
    handshake16();
    send16(16'h8000, 16'h8000, 1'b0, lat, rok);
    n_chk++; if ({ovf16, co16, s16} !== {1'b1, 17'h10000}) begin n_fail++; $display("FAIL ovf_8000 got ovf=%b res=%h want 1 10000", ovf16, {co16, s16}); end
    handshake16();
    send16(16'h0001, 16'hFFFF, 1'b0, lat, rok);
    n_chk++; if ({ovf16, co16, s16} !== {1'b0, 17'h10000}) begin n_fail++; $display("FAIL ovf_0001 got ovf=%b res=%h want 0 10000", ovf16, {co16, s16}); end
    handshake16();
  endtask
`endif

  // Both widths streamed with in_valid/out_ready high; results checked in order
  // against plain a+b+cin, accept spacing checked against NIBBLES+2.
  task automatic test_back_to_back();
    logic [16:0] q16[$];
    logic [4:0]  q4[$];
    logic [16:0] e16;
    logic [4:0]  e4;
    int last16 = -1, last4 = -1, acc16 = 0, acc4 = 0;
    iv16 = 1; or16 = 1; iv4 = 1; or4 = 1;
    for (int cyc = 0; cyc < 140; cyc++) begin
      if (cyc == 120) begin iv16 = 0; iv4 = 0; end
      if (ov16) begin
        e16 = (q16.size() > 0) ? q16.pop_front() : 17'h1xxxx;
        n_chk++; if ({co16, s16} !== e16) begin n_fail++; $display("FAIL b2b16 cyc %0d got %h want %h", cyc, {co16, s16}, e16); end
      end
      if (ov4) begin
        e4 = (q4.size() > 0) ? q4.pop_front() : 5'h1x;
        n_chk++; if ({co4, s4} !== e4) begin n_fail++; $display("FAIL b2b4 cyc %0d got %h want %h", cyc, {co4, s4}, e4); end
      end
      a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
      a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
      if (iv16 && ir16) begin
        if (last16 >= 0) begin
          n_chk++; if (cyc - last16 != 6) begin n_fail++; $display("FAIL interval16 got %0d want 6", cyc - last16); end
        end
        last16 = cyc; acc16++;
        q16.push_back({1'b0, a16} + {1'b0, b16} + 17'(c16));
      end
      if (iv4 && ir4) begin
        if (last4 >= 0) begin
          n_chk++; if (cyc - last4 != 3) begin n_fail++; $display("FAIL interval4 got %0d want 3", cyc - last4); end
        end
        last4 = cyc; acc4++;
        q4.push_back({1'b0, a4} + {1'b0, b4} + 5'(c4));
      end
      @(posedge clk);
      @(negedge clk);
    end
    n_chk++; if (q16.size() != 0 || acc16 < 15) begin n_fail++; $display("FAIL drain16 left %0d accepted %0d want 0 and >=15", q16.size(), acc16); end
    n_chk++; if (q4.size() != 0 || acc4 < 30) begin n_fail++; $display("FAIL drain4 left %0d accepted %0d want 0 and >=30", q4.size(), acc4); end
    or16 = 0; or4 = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid();
`ifdef ADDER_OVF_EN
    test_ovf();
`endif
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
